store_write_buffer: RTL and testbench

- Data-side write buffer directly downstream of the CPU core's store port (data address, write data, write strobe).
- Captures CPU stores into a DEPTH-entry FIFO so a store completes in one cycle, then drains them to the word-wide data memory over a valid/ready handshake.
- Forwards pending store data to CPU loads that hit a buffered word.
- Stalls the core only when full and the store cannot coalesce.

---
 rtl/store_write_buffer_pkg.sv | 19 +
 rtl/store_write_buffer_if.sv | 15 +
 rtl/store_write_buffer_fwd_match.sv | 32 +++
 rtl/store_write_buffer.sv | 99 +++++++++
 tb/tb_store_write_buffer.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/store_write_buffer_pkg.sv
// Shared constants and types for the CPU store write buffer.
// Address matching works on word addresses; bits below WORD_LSB are only carried through.
package store_write_buffer_pkg;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_AW    = 32;
  localparam int DEF_DW    = 32;
  localparam int WORD_LSB  = 2;
  localparam int PTR_W     = $clog2(DEF_DEPTH);

  typedef struct packed {
    logic              valid;
    logic [DEF_AW-1:0] addr;
    logic [DEF_DW-1:0] data;
  } entry_t;

  function automatic logic [DEF_AW-WORD_LSB-1:0] word_of(input logic [DEF_AW-1:0] a);
    return a[DEF_AW-1:WORD_LSB];
  endfunction
endpackage

// File: rtl/store_write_buffer_if.sv
// Word-wide drain bus from the write buffer (master) to data memory (slave).
interface store_write_buffer_if
  import store_write_buffer_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
);
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_data;
  logic          o_mem_valid;
  logic          i_mem_ready;

  modport master (output o_mem_addr, o_mem_data, o_mem_valid, input i_mem_ready);
  modport slave  (input o_mem_addr, o_mem_data, o_mem_valid, output i_mem_ready);
endinterface

// File: rtl/store_write_buffer_fwd_match.sv
// Age-ordered word comparator: walks entries from head towards tail, so the last match
// seen is the youngest one.
module wb_fwd_match #(
  parameter int DEPTH = 4,
  parameter int WW    = 30,
  parameter int DW    = 32,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]         valid_i,
  input  logic [DEPTH-1:0][WW-1:0] word_i,
  input  logic [DEPTH-1:0][DW-1:0] data_i,
  input  logic [PW-1:0]            head_i,
  input  logic [PW:0]              count_i,
  input  logic [WW-1:0]            lookup_i,
  output logic                     hit_o,
  output logic [DW-1:0]            data_o
);
  logic [PW-1:0] idx;

  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_i + PW'(k);
      if ((PW+1)'(k) < count_i && valid_i[idx] && word_i[idx] == lookup_i) begin
        hit_o  = 1'b1;
        data_o = data_i[idx];
      end
    end
  end
endmodule

// File: rtl/store_write_buffer.sv
// DEPTH-entry store FIFO between the CPU store port and data memory, with load
// forwarding and coalescing of repeated stores into the youngest entry.
module store_write_buffer
  import store_write_buffer_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = DEF_AW,
  parameter int DW    = DEF_DW
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [AW-1:0]            i_addr,
  input  logic [DW-1:0]            i_write_data,
  input  logic                     i_SIG_write,
  input  logic                     i_rd_en,
  output logic                     o_stall,
  output logic                     o_fwd_hit,
  output logic [DW-1:0]            o_fwd_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty,
  store_write_buffer_if.master     mem
);
  localparam int PW = $clog2(DEPTH);
  localparam int WW = AW - WORD_LSB;

  logic [DEPTH-1:0]         valid_q;
  logic [DEPTH-1:0][AW-1:0] addr_q;
  logic [DEPTH-1:0][DW-1:0] data_q;
  logic [DEPTH-1:0][WW-1:0] word;
  logic [PW-1:0]            head_q, head_d, tail_q, tail_d, youngest;
  logic [PW:0]              count_q, count_d;
  logic                     empty, full, enq, deq, coal;
  logic                     fwd_hit, coal_hit;
  logic [DW-1:0]            fwd_data, coal_data_unused;

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    assign word[i] = addr_q[i][AW-1:WORD_LSB];
  end

  assign youngest = tail_q - 1'b1;
  assign empty    = (count_q == '0);
  assign full     = (count_q == (PW+1)'(DEPTH));

  wb_fwd_match #(.DEPTH(DEPTH), .WW(WW), .DW(DW)) u_fwd (
    .valid_i(valid_q), .word_i(word), .data_i(data_q),
    .head_i(head_q), .count_i(count_q), .lookup_i(i_addr[AW-1:WORD_LSB]),
    .hit_o(fwd_hit), .data_o(fwd_data)
  );

  // Same comparator restricted to the youngest entry decides coalescing.
  wb_fwd_match #(.DEPTH(DEPTH), .WW(WW), .DW(DW)) u_coal (
    .valid_i(valid_q), .word_i(word), .data_i(data_q),
    .head_i(youngest), .count_i((PW+1)'(1)), .lookup_i(i_addr[AW-1:WORD_LSB]),
    .hit_o(coal_hit), .data_o(coal_data_unused)
  );

  // count >= 2 keeps coalescing off the head, which may be mid-handshake.
  assign coal    = i_SIG_write && (count_q >= (PW+1)'(2)) && coal_hit;
  assign enq     = i_SIG_write && !coal && !full;
  assign deq     = mem.o_mem_valid && mem.i_mem_ready;
  assign o_stall = i_SIG_write && !coal && full;

  assign head_d  = deq ? head_q + 1'b1 : head_q;
  assign tail_d  = enq ? tail_q + 1'b1 : tail_q;
  assign count_d = count_q + (PW+1)'(enq) - (PW+1)'(deq);

  assign o_fwd_hit       = i_rd_en && fwd_hit;
  assign o_fwd_data      = o_fwd_hit ? fwd_data : '0;
  assign o_count         = count_q;
  assign o_empty         = empty;
  assign mem.o_mem_valid = !empty;
  assign mem.o_mem_addr  = empty ? '0 : addr_q[head_q];
  assign mem.o_mem_data  = empty ? '0 : data_q[head_q];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (deq) valid_q[head_q] <= 1'b0;
      if (enq) begin
        valid_q[tail_q] <= 1'b1;
        addr_q[tail_q]  <= i_addr;
        data_q[tail_q]  <= i_write_data;
      end
      if (coal) begin
        addr_q[youngest] <= i_addr;
        data_q[youngest] <= i_write_data;
      end
    end
  end
endmodule

// File: tb/tb_store_write_buffer.sv
// Directed bench for store_write_buffer: drives at negedge, checks shortly after.
module tb_store_write_buffer;
  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] i_addr, i_write_data, o_fwd_data;
  logic        i_SIG_write, i_rd_en, o_stall, o_fwd_hit, o_empty;
  logic [2:0]  o_count;
  int          n_cmp = 0;
  int          n_err = 0;

  store_write_buffer_if #(.AW(32), .DW(32)) mem ();

  store_write_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk(clk), .rstn(rstn), .i_addr(i_addr), .i_write_data(i_write_data),
    .i_SIG_write(i_SIG_write), .i_rd_en(i_rd_en), .o_stall(o_stall),
    .o_fwd_hit(o_fwd_hit), .o_fwd_data(o_fwd_data), .o_count(o_count),
    .o_empty(o_empty), .mem(mem)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1);
  end

  task automatic idle();
    i_SIG_write = 1'b0; i_rd_en = 1'b0; mem.i_mem_ready = 1'b0;
  endtask

  task automatic put(input logic [31:0] a, input logic [31:0] d);
    i_addr = a; i_write_data = d; i_SIG_write = 1'b1;
    @(negedge clk);
    i_SIG_write = 1'b0;
  endtask

  task automatic drain_all();
    mem.i_mem_ready = 1'b1;
    for (int c = 0; c < 10 && !o_empty; c++) @(negedge clk);
    mem.i_mem_ready = 1'b0;
    #1;
    n_cmp++; if (o_empty !== 1'b1) begin n_err++; $display("FAIL drain_empty: got %b exp 1", o_empty); end
  endtask

  task automatic test_reset();
    rstn = 1'b0; idle(); i_addr = 32'h0; i_write_data = 32'h0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    i_rd_en = 1'b1; i_addr = 32'h10;
    #1;
    n_cmp++; if (mem.o_mem_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b exp 0", mem.o_mem_valid); end
    n_cmp++; if (o_empty !== 1'b1) begin n_err++; $display("FAIL rst_empty: got %b exp 1", o_empty); end
    n_cmp++; if (o_count !== 3'd0) begin n_err++; $display("FAIL rst_count: got %0d exp 0", o_count); end
    n_cmp++; if (o_stall !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %b exp 0", o_stall); end
    n_cmp++; if (o_fwd_hit !== 1'b0 || o_fwd_data !== 32'h0) begin n_err++; $display("FAIL rst_fwd: got %b/%h exp 0/0", o_fwd_hit, o_fwd_data); end
    n_cmp++; if (mem.o_mem_addr !== 32'h0 || mem.o_mem_data !== 32'h0) begin n_err++; $display("FAIL rst_mem: got %h/%h exp 0/0", mem.o_mem_addr, mem.o_mem_data); end
    i_rd_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    put(32'h10, 32'hDEADBEEF);
    for (int c = 0; c < 5; c++) begin
      #1;
      n_cmp++; if (mem.o_mem_valid !== 1'b1 || mem.o_mem_addr !== 32'h10 || mem.o_mem_data !== 32'hDEADBEEF || o_count !== 3'd1) begin
        n_err++; $display("FAIL single_hold[%0d]: got v=%b a=%h d=%h c=%0d exp 1/10/deadbeef/1", c, mem.o_mem_valid, mem.o_mem_addr, mem.o_mem_data, o_count);
      end
      @(negedge clk);
    end
    mem.i_mem_ready = 1'b1;
    @(negedge clk);
    mem.i_mem_ready = 1'b0;
    #1;
    n_cmp++; if (o_empty !== 1'b1 || o_count !== 3'd0) begin n_err++; $display("FAIL single_drain: got e=%b c=%0d exp 1/0", o_empty, o_count); end
    @(negedge clk);
  endtask

  task automatic test_full_coalesce();
    logic [31:0] ea [4];
    logic [31:0] ed [4];
    ea = '{32'h00, 32'h04, 32'h08, 32'h0C};
    ed = '{32'hA0, 32'hA1, 32'hA2, 32'h55};
    for (int i = 0; i < 4; i++) put(32'(i * 4), 32'hA0 + 32'(i));
    i_addr = 32'h20; i_write_data = 32'h99; i_SIG_write = 1'b1;
    #1;
    n_cmp++; if (o_count !== 3'd4) begin n_err++; $display("FAIL full_count: got %0d exp 4", o_count); end
    n_cmp++; if (o_stall !== 1'b1) begin n_err++; $display("FAIL full_stall: got %b exp 1", o_stall); end
    @(negedge clk);
    i_addr = 32'h0C; i_write_data = 32'h55;
    #1;
    n_cmp++; if (o_stall !== 1'b0) begin n_err++; $display("FAIL coal_stall: got %b exp 0", o_stall); end
    @(negedge clk);
    i_SIG_write = 1'b0;
    #1;
    n_cmp++; if (o_count !== 3'd4) begin n_err++; $display("FAIL coal_count: got %0d exp 4", o_count); end
    mem.i_mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (mem.o_mem_valid !== 1'b1 || mem.o_mem_addr !== ea[i] || mem.o_mem_data !== ed[i]) begin
        n_err++; $display("FAIL full_drain[%0d]: got v=%b a=%h d=%h exp 1/%h/%h", i, mem.o_mem_valid, mem.o_mem_addr, mem.o_mem_data, ea[i], ed[i]);
      end
      @(negedge clk);
    end
    mem.i_mem_ready = 1'b0;
    #1;
    n_cmp++; if (o_empty !== 1'b1) begin n_err++; $display("FAIL full_empty: got %b exp 1", o_empty); end
    @(negedge clk);
  endtask

  task automatic test_forward();
    put(32'h40, 32'h1111);
    put(32'h44, 32'h2222);
    put(32'h40, 32'h3333);
    i_rd_en = 1'b1; i_addr = 32'h42;
    #1;
    n_cmp++; if (o_count !== 3'd3) begin n_err++; $display("FAIL fwd_count: got %0d exp 3", o_count); end
    n_cmp++; if (o_fwd_hit !== 1'b1 || o_fwd_data !== 32'h3333) begin n_err++; $display("FAIL fwd_young: got %b/%h exp 1/3333", o_fwd_hit, o_fwd_data); end
    i_addr = 32'h48;
    #1;
    n_cmp++; if (o_fwd_hit !== 1'b0 || o_fwd_data !== 32'h0) begin n_err++; $display("FAIL fwd_miss: got %b/%h exp 0/0", o_fwd_hit, o_fwd_data); end
    i_addr = 32'h44; i_rd_en = 1'b0;
    #1;
    n_cmp++; if (o_fwd_hit !== 1'b0) begin n_err++; $display("FAIL fwd_noload: got %b exp 0", o_fwd_hit); end
    i_rd_en = 1'b1; i_addr = 32'h50; i_write_data = 32'h77; i_SIG_write = 1'b1;
    #1;
    n_cmp++; if (o_fwd_hit !== 1'b0) begin n_err++; $display("FAIL fwd_same_cycle: got %b exp 0", o_fwd_hit); end
    @(negedge clk);
    i_SIG_write = 1'b0;
    #1;
    n_cmp++; if (o_fwd_hit !== 1'b1 || o_fwd_data !== 32'h77) begin n_err++; $display("FAIL fwd_after: got %b/%h exp 1/77", o_fwd_hit, o_fwd_data); end
    i_rd_en = 1'b0;
    drain_all();
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [63:0] q[$];
    logic [63:0] exp_e;
    put(32'h100, 32'h1); q.push_back({32'h100, 32'h1});
    put(32'h104, 32'h2); q.push_back({32'h104, 32'h2});
    mem.i_mem_ready = 1'b1;
    for (int n = 0; n < 12; n++) begin
      i_addr = 32'h200 + 32'(4 * n); i_write_data = 32'h1000 + 32'(n); i_SIG_write = 1'b1;
      #1;
      exp_e = q.pop_front();
      n_cmp++; if ({mem.o_mem_addr, mem.o_mem_data} !== exp_e || o_stall !== 1'b0) begin
        n_err++; $display("FAIL b2b_head[%0d]: got %h/%h st=%b exp %h st=0", n, mem.o_mem_addr, mem.o_mem_data, o_stall, exp_e);
      end
      q.push_back({i_addr, i_write_data});
      @(negedge clk);
      #1;
      n_cmp++; if (o_count !== 3'd2) begin n_err++; $display("FAIL b2b_count[%0d]: got %0d exp 2", n, o_count); end
    end
    i_SIG_write = 1'b0;
    for (int n = 0; n < 2; n++) begin
      exp_e = q.pop_front();
      n_cmp++; if ({mem.o_mem_addr, mem.o_mem_data} !== exp_e) begin
        n_err++; $display("FAIL b2b_tail[%0d]: got %h/%h exp %h", n, mem.o_mem_addr, mem.o_mem_data, exp_e);
      end
      @(negedge clk);
      #1;
    end
    mem.i_mem_ready = 1'b0;
    n_cmp++; if (o_empty !== 1'b1) begin n_err++; $display("FAIL b2b_empty: got %b exp 1", o_empty); end
    @(negedge clk);
  endtask

  task automatic test_no_coal_head();
    put(32'h60, 32'hAA);
    put(32'h60, 32'hBB);
    #1;
    n_cmp++; if (o_count !== 3'd2) begin n_err++; $display("FAIL head_count: got %0d exp 2", o_count); end
    n_cmp++; if (mem.o_mem_data !== 32'hAA || mem.o_mem_addr !== 32'h60) begin n_err++; $display("FAIL head_data: got %h/%h exp 60/aa", mem.o_mem_addr, mem.o_mem_data); end
    put(32'h61, 32'hCC);
    #1;
    n_cmp++; if (o_count !== 3'd2) begin n_err++; $display("FAIL tail_coal_count: got %0d exp 2", o_count); end
    mem.i_mem_ready = 1'b1;
    n_cmp++; if (mem.o_mem_data !== 32'hAA) begin n_err++; $display("FAIL head_first: got %h exp aa", mem.o_mem_data); end
    @(negedge clk);
    #1;
    n_cmp++; if (mem.o_mem_addr !== 32'h61 || mem.o_mem_data !== 32'hCC) begin n_err++; $display("FAIL head_second: got %h/%h exp 61/cc", mem.o_mem_addr, mem.o_mem_data); end
    @(negedge clk);
    mem.i_mem_ready = 1'b0;
    #1;
    n_cmp++; if (o_empty !== 1'b1) begin n_err++; $display("FAIL head_empty: got %b exp 1", o_empty); end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    put(32'h80, 32'h8);
    put(32'h84, 32'h9);
    put(32'h88, 32'hA);
    #1;
    n_cmp++; if (o_count !== 3'd3) begin n_err++; $display("FAIL ar_pre_count: got %0d exp 3", o_count); end
    #1 rstn = 1'b0;
    #1;
    n_cmp++; if (mem.o_mem_valid !== 1'b0 || o_count !== 3'd0) begin n_err++; $display("FAIL ar_immediate: got v=%b c=%0d exp 0/0", mem.o_mem_valid, o_count); end
    @(negedge clk);
    rstn = 1'b1;
    i_rd_en = 1'b1; i_addr = 32'h84;
    #1;
    n_cmp++; if (o_fwd_hit !== 1'b0 || o_empty !== 1'b1) begin n_err++; $display("FAIL ar_fwd: got hit=%b e=%b exp 0/1", o_fwd_hit, o_empty); end
    i_rd_en = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_coalesce();
    test_forward();
    test_back_to_back();
    test_no_coal_head();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
